fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//   Controller for the instruction-fetch stage of the 16-bit RISC pipeline. Each cycle it selects
//   the next PC: sequential, predicted-taken, or resolved-branch redirect. It holds the PC on
//   pipeline stalls and inserts flush bubbles after a redirect. It drives PC and branch_predict
//   of instr_fetch_module and tells IF/ID whether the fetched IR is valid.
// PARAMETERS
//   PC_W          16      PC / address width
//   RESET_PC      16'h0   PC value loaded by reset
//   FLUSH_CYCLES  2       bubble cycles after a redirect (legal range 1..7)
// PORTS
//   CLK             in   1     system clock; rising edge only
//   reset           in   1     synchronous, active-high reset
//   stall           in   1     hazard unit: hold PC this cycle
//   redirect        in   1     EX: branch/jump resolved against prediction
//   redirect_pc     in   PC_W  correct target when redirect=1
//   predict_taken   in   1     decode: branch predicted taken
//   predict_pc      in   PC_W  predicted target when predict_taken=1
//   PC              out  PC_W  fetch address to instr_fetch_module
//   branch_predict  out  1     to instr_fetch_module; 1 = PC came from a prediction
//   fetch_valid     out  1     IR of this cycle is a real instruction
//   flush           out  1     kill IF/ID contents
//   seq_state       out  2     current FSM state (debug)
// BEHAVIOUR
//   - All outputs are registered. Every decision made at edge N is visible after edge N.
//   - Reset (synchronous, dominates all inputs, any state, mid-flush too):
//     PC=RESET_PC, branch_predict=0, fetch_valid=0, flush=0, flush counter=0, state=IDLE.
//   - States:
//     - IDLE=2'd0: one cycle after reset, then RUN. PC held; IDLE ignores stall/redirect/predict.
//     - RUN=2'd1, STALL=2'd2, FLUSH=2'd3.
//   - Input priority in RUN/STALL: redirect > stall > predict_taken > sequential.
//   - RUN:
//     - redirect: PC<=redirect_pc; FLUSH; counter<=FLUSH_CYCLES-1; flush<=1; fetch_valid<=0.
//     - stall: PC held; STALL; fetch_valid<=0.
//     - predict_taken: PC<=predict_pc; branch_predict<=1 for that cycle; fetch_valid<=1.
//     - otherwise: PC<=PC+1 (mod 2^PC_W, so 16'hFFFF->16'h0000); branch_predict<=0; fetch_valid<=1.
//   - STALL:
//     - PC and branch_predict held.
//     - Stays in STALL while stall=1.
//     - When stall=0, resumes exactly as RUN with the same cycle's inputs.
//     - redirect in STALL acts as in RUN.
//   - FLUSH:
//     - PC held at the target; flush=1; fetch_valid=0; branch_predict=0; stall and predict_taken ignored.
//     - counter decrements. At counter==0, next state is RUN with flush<=0 and fetch_valid<=1.
//       The target instruction is then fetched at the held PC, and PC advances on the following cycle.
//     - A new redirect restarts FLUSH: new PC, counter reloaded.
//   - Latency: redirect -> first valid fetch after FLUSH_CYCLES+1 edges. Stall release -> valid on next edge.
//   - flush and fetch_valid are never both 1.
// CONFIGURATION
//   STATIC_PREDICT_EN
//     - Defined: predict_taken/predict_pc are honoured as described above.
//     - Undefined: predict_taken is ignored and branch_predict is tied 0. PC changes only
//       sequentially or by redirect. predict_pc is unused.
// TESTING
//   1. reset=1 for 2 cycles, then 0 -> PC=0, valid=0 in IDLE; next edges PC=0,1,2 with fetch_valid=1.
//   2. stall=1 for 3 cycles at PC=5 -> PC stays 5, fetch_valid=0, seq_state=2; release -> PC=6, valid=1.
//   3. redirect=1, redirect_pc=16'h0040, FLUSH_CYCLES=2 -> flush=1 for 2 cycles, PC=0x40 held;
//      then valid=1 at 0x40, next cycle 0x41.
//   4. Same-cycle redirect+stall+predict_taken -> redirect wins. Redirect again mid-FLUSH -> new PC, counter reloaded.
//   5. STATIC_PREDICT_EN defined: predict_taken with predict_pc=0x0010 -> PC=0x10, branch_predict=1 for one cycle.
//      Undefined: the same stimulus gives PC+1 and branch_predict=0.
//   6. PC=16'hFFFF sequential -> 16'h0000. reset asserted during FLUSH -> all outputs back to reset values next edge.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer_if
// Description : Bundle between the fetch sequencer and the pipeline (hazard
//               unit, decode, EX, instr_fetch_module, IF/ID register).
//               The master side is the sequencer; the slave side is the pipeline.
// Revision    : 1.0  initial release
// ============================================================================
interface fetch_sequencer_if #(
    parameter int PC_W = 16
);
    logic            stall;
    logic            redirect;
    logic [PC_W-1:0] redirect_pc;
    logic            predict_taken;
    logic [PC_W-1:0] predict_pc;
    logic [PC_W-1:0] PC;
    logic            branch_predict;
    logic            fetch_valid;
    logic            flush;
    logic [1:0]      seq_state;

    modport master (
        input  stall, redirect, redirect_pc, predict_taken, predict_pc,
        output PC, branch_predict, fetch_valid, flush, seq_state
    );

    modport slave (
        output stall, redirect, redirect_pc, predict_taken, predict_pc,
        input  PC, branch_predict, fetch_valid, flush, seq_state
    );
endinterface
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer
// Description : Instruction-fetch PC controller. Chooses between sequential,
//               predicted-taken and redirect PCs, holds on stalls and inserts
//               FLUSH_CYCLES bubbles after every redirect. All outputs are
//               registered.
//               Build option: STATIC_PREDICT_EN - when defined, predict_taken /
//               predict_pc steer the PC; otherwise prediction is ignored and
//               branch_predict stays 0.
// Revision    : 1.0  initial release
// ============================================================================
module fetch_sequencer #(
    parameter int              PC_W         = 16,
    parameter logic [PC_W-1:0] RESET_PC     = '0,
    parameter int              FLUSH_CYCLES = 2
) (
    input  wire logic          CLK,
    input  wire logic          reset,
    fetch_sequencer_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2,
        FLUSH = 2'd3
    } state_t;

    // Counter is loaded with FLUSH_CYCLES-1 so that exactly FLUSH_CYCLES
    // cycles show flush=1 before the target is fetched.
    localparam logic [2:0] c_flush_load = 3'(FLUSH_CYCLES - 1);

    state_t          r_state;
    logic [PC_W-1:0] r_pc;
    logic [2:0]      r_cnt;
    logic            r_bp;
    logic            r_valid;
    logic            r_flush;

    logic            w_take_pred;
    logic [PC_W-1:0] w_pred_pc;

`ifdef STATIC_PREDICT_EN
    assign w_take_pred = bus.predict_taken;
    assign w_pred_pc   = bus.predict_pc;
`else
    // Prediction disabled: the decode hint is ignored and PC only moves
    // sequentially or by redirect.
    logic w_unused_pred;
    assign w_unused_pred = bus.predict_taken ^ (^bus.predict_pc);
    assign w_take_pred   = 1'b0;
    assign w_pred_pc     = '0;
`endif

    // Sequencer FSM: next PC selection, stall hold and flush bubble counting.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state <= IDLE;
            r_pc    <= RESET_PC;
            r_cnt   <= 3'd0;
            r_bp    <= 1'b0;
            r_valid <= 1'b0;
            r_flush <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    // First real fetch is at RESET_PC itself.
                    r_state <= RUN;
                    r_valid <= 1'b1;
                    r_flush <= 1'b0;
                    r_bp    <= 1'b0;
                end
                RUN, STALL: begin
                    if (bus.redirect) begin
                        r_pc    <= bus.redirect_pc;
                        r_state <= FLUSH;
                        r_cnt   <= c_flush_load;
                        r_flush <= 1'b1;
                        r_valid <= 1'b0;
                        r_bp    <= 1'b0;
                    end else if (bus.stall) begin
                        // PC and branch_predict hold their values.
                        r_state <= STALL;
                        r_valid <= 1'b0;
                    end else if (w_take_pred) begin
                        r_pc    <= w_pred_pc;
                        r_state <= RUN;
                        r_bp    <= 1'b1;
                        r_valid <= 1'b1;
                    end else begin
                        r_pc    <= r_pc + PC_W'(1);
                        r_state <= RUN;
                        r_bp    <= 1'b0;
                        r_valid <= 1'b1;
                    end
                end
                FLUSH: begin
                    r_bp <= 1'b0;
                    if (bus.redirect) begin
                        r_pc    <= bus.redirect_pc;
                        r_cnt   <= c_flush_load;
                        r_flush <= 1'b1;
                        r_valid <= 1'b0;
                    end else if (r_cnt == 3'd0) begin
                        // Target is fetched at the held PC; PC advances next cycle.
                        r_state <= RUN;
                        r_flush <= 1'b0;
                        r_valid <= 1'b1;
                    end else begin
                        r_cnt   <= r_cnt - 3'd1;
                        r_flush <= 1'b1;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                    r_flush <= 1'b0;
                    r_bp    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.PC          = r_pc;
    assign bus.fetch_valid = r_valid;
    assign bus.flush       = r_flush;
    assign bus.seq_state   = r_state;
`ifdef STATIC_PREDICT_EN
    assign bus.branch_predict = r_bp;
`else
    logic w_unused_bp;
    assign w_unused_bp        = r_bp;
    assign bus.branch_predict = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_sequencer
// Description : Directed self-checking bench for fetch_sequencer
//               (PC_W=16, RESET_PC=0, FLUSH_CYCLES=2).
// Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_sequencer;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    fetch_sequencer_if #(.PC_W(16)) bus ();

    fetch_sequencer #(
        .PC_W         (16),
        .RESET_PC     (16'h0000),
        .FLUSH_CYCLES (2)
    ) dut (
        .CLK   (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [15:0] pc,
                              input logic v, input logic f,
                              input logic bp, input logic [1:0] st);
        total++;
        assert (bus.PC === pc) else begin
            bad++; $error("FAIL %s.PC observed=%h expected=%h", tag, bus.PC, pc);
        end
        total++;
        assert (bus.fetch_valid === v) else begin
            bad++; $error("FAIL %s.valid observed=%b expected=%b", tag, bus.fetch_valid, v);
        end
        total++;
        assert (bus.flush === f) else begin
            bad++; $error("FAIL %s.flush observed=%b expected=%b", tag, bus.flush, f);
        end
        total++;
        assert (bus.branch_predict === bp) else begin
            bad++; $error("FAIL %s.bp observed=%b expected=%b", tag, bus.branch_predict, bp);
        end
        total++;
        assert (bus.seq_state === st) else begin
            bad++; $error("FAIL %s.state observed=%0d expected=%0d", tag, bus.seq_state, st);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst               = 1'b1;
        bus.stall         = 1'b0;
        bus.redirect      = 1'b0;
        bus.redirect_pc   = 16'h0000;
        bus.predict_taken = 1'b0;
        bus.predict_pc    = 16'h0000;

        // Reset held two cycles, then IDLE -> RUN at PC 0
        step(); step();
        expect_out("reset", 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0);
        rst = 1'b0;
        step(); expect_out("first_fetch", 16'h0000, 1'b1, 1'b0, 1'b0, 2'd1);
        step(); expect_out("seq1", 16'h0001, 1'b1, 1'b0, 1'b0, 2'd1);
        step(); expect_out("seq2", 16'h0002, 1'b1, 1'b0, 1'b0, 2'd1);
        step(); step(); step();
        expect_out("seq5", 16'h0005, 1'b1, 1'b0, 1'b0, 2'd1);

        // Stall three cycles at PC 5, then release
        bus.stall = 1'b1;
        step(); expect_out("stall1", 16'h0005, 1'b0, 1'b0, 1'b0, 2'd2);
        step(); expect_out("stall2", 16'h0005, 1'b0, 1'b0, 1'b0, 2'd2);
        step(); expect_out("stall3", 16'h0005, 1'b0, 1'b0, 1'b0, 2'd2);
        bus.stall = 1'b0;
        step(); expect_out("release", 16'h0006, 1'b1, 1'b0, 1'b0, 2'd1);

        // Redirect to 0x40 with two flush bubbles
        bus.redirect = 1'b1; bus.redirect_pc = 16'h0040;
        step(); expect_out("redir_f1", 16'h0040, 1'b0, 1'b1, 1'b0, 2'd3);
        bus.redirect = 1'b0;
        step(); expect_out("redir_f2", 16'h0040, 1'b0, 1'b1, 1'b0, 2'd3);
        step(); expect_out("redir_tgt", 16'h0040, 1'b1, 1'b0, 1'b0, 2'd1);
        step(); expect_out("redir_next", 16'h0041, 1'b1, 1'b0, 1'b0, 2'd1);

        // Same-cycle redirect + stall + predict: redirect wins
        bus.redirect = 1'b1; bus.redirect_pc = 16'h0080;
        bus.stall = 1'b1; bus.predict_taken = 1'b1; bus.predict_pc = 16'h0010;
        step(); expect_out("prio_f1", 16'h0080, 1'b0, 1'b1, 1'b0, 2'd3);
        bus.redirect = 1'b0; bus.stall = 1'b0; bus.predict_taken = 1'b0;
        step(); expect_out("prio_f2", 16'h0080, 1'b0, 1'b1, 1'b0, 2'd3);
        // Redirect while counter is at 0: restarts the full flush
        bus.redirect = 1'b1; bus.redirect_pc = 16'h0090;
        step(); expect_out("reflush1", 16'h0090, 1'b0, 1'b1, 1'b0, 2'd3);
        // stall/predict must be ignored during FLUSH
        bus.redirect = 1'b0; bus.stall = 1'b1; bus.predict_taken = 1'b1;
        step(); expect_out("reflush2", 16'h0090, 1'b0, 1'b1, 1'b0, 2'd3);
        step(); expect_out("reflush_tgt", 16'h0090, 1'b1, 1'b0, 1'b0, 2'd1);
        bus.stall = 1'b0; bus.predict_taken = 1'b0;
        step(); expect_out("reflush_next", 16'h0091, 1'b1, 1'b0, 1'b0, 2'd1);

        // Predict-taken to 0x10
        bus.predict_taken = 1'b1; bus.predict_pc = 16'h0010;
        step();
`ifdef STATIC_PREDICT_EN
        expect_out("pred", 16'h0010, 1'b1, 1'b0, 1'b1, 2'd1);
`else
        expect_out("pred", 16'h0092, 1'b1, 1'b0, 1'b0, 2'd1);
`endif
        bus.predict_taken = 1'b0;
        step();
`ifdef STATIC_PREDICT_EN
        expect_out("pred_next", 16'h0011, 1'b1, 1'b0, 1'b0, 2'd1);
`else
        expect_out("pred_next", 16'h0093, 1'b1, 1'b0, 1'b0, 2'd1);
`endif

        // Redirect from STALL
        bus.stall = 1'b1;
        step(); expect_out("stall_pre", bus.PC, 1'b0, 1'b0, 1'b0, 2'd2);
        bus.redirect = 1'b1; bus.redirect_pc = 16'h0020;
        step(); expect_out("stall_redir", 16'h0020, 1'b0, 1'b1, 1'b0, 2'd3);
        bus.redirect = 1'b0; bus.stall = 1'b0;
        step(); step();
        expect_out("stall_redir_tgt", 16'h0020, 1'b1, 1'b0, 1'b0, 2'd1);

        // PC wrap 0xFFFF -> 0x0000
        bus.redirect = 1'b1; bus.redirect_pc = 16'hFFFF;
        step();
        bus.redirect = 1'b0;
        step(); step();
        expect_out("wrap_tgt", 16'hFFFF, 1'b1, 1'b0, 1'b0, 2'd1);
        step(); expect_out("wrap", 16'h0000, 1'b1, 1'b0, 1'b0, 2'd1);

        // Reset in the middle of FLUSH
        bus.redirect = 1'b1; bus.redirect_pc = 16'h1234;
        step(); expect_out("pre_rst_flush", 16'h1234, 1'b0, 1'b1, 1'b0, 2'd3);
        bus.redirect = 1'b0; rst = 1'b1;
        step(); expect_out("rst_in_flush", 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0);
        rst = 1'b0;
        step(); expect_out("post_rst", 16'h0000, 1'b1, 1'b0, 1'b0, 2'd1);
        step(); expect_out("post_rst_seq", 16'h0001, 1'b1, 1'b0, 1'b0, 2'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
